// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern-source selector.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SWEEP  = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/bist_sel_mux.sv
// Combinational NUM_SRC:1 pattern selector; an out-of-range select yields all zeros.
module bist_sel_mux
    import bist_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         data
);

    logic [WIDTH-1:0] src_arr [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Compare against each legal index so an unused select code can never index past the array.
    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                data = src_arr[k];
            end
        end
    end

endmodule

// File: rtl/bist_pattern_sel.sv
// Registered N:1 BIST pattern-source selector with MANUAL and SWEEP modes and a
// valid/ready output stream.
module bist_pattern_sel
    import bist_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic                     start,
    input  logic                     abort,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         cur_src,
    output logic                     busy,
    output logic                     sweep_done
);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_last_q;
    logic [WIDTH-1:0]     out_data_q;
    logic                 out_valid_q;
    logic [SEL_W-1:0]     cur_src_q;
    logic                 busy_q;
    logic                 sweep_done_q;

    logic                 beat;
    logic                 busy_d;
    logic                 ld;
    logic [SEL_W-1:0]     mux_sel;
    logic [WIDTH-1:0]     mux_data;

    assign beat = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (mode == MODE_SWEEP) ? SWEEP : MANUAL;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            MANUAL: begin
                if (abort) begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (beat) begin
                    if (cnt_q == dwell_last_q) begin
                        cnt_d = '0;
                        if (idx_q == SEL_W'(NUM_SRC - 1)) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + SEL_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d  = (state_d != IDLE);
    assign ld      = busy_d & (~out_valid_q | out_ready);
    // Load from the post-advance index so the register always shows the beat being offered next.
    assign mux_sel = (state_d == SWEEP) ? idx_d : sel;

    bist_sel_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_data (src_data),
        .sel      (mux_sel),
        .data     (mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            dwell_last_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            cur_src_q    <= '0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= busy_d;
            busy_q      <= busy_d;
            if (state_q == IDLE && start) begin
                dwell_last_q <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            end
            if (ld) begin
                out_data_q <= mux_data;
                cur_src_q  <= mux_sel;
            end
            sweep_done_q <= (state_q == SWEEP) && (state_d == IDLE) && !abort;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign cur_src    = cur_src_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;

endmodule
